// File: rtl/exe_pkg.sv
// Shared encodings for the multi-cycle execute stage: opcodes, status-flag bit positions,
// forwarding-select codes and the multiply FSM state type.
package exe_pkg;

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;
  localparam logic [3:0] CmdMul = 4'b1010;

  // Bit positions inside the {N,Z,C,V} status nibble.
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  localparam logic [1:0] FuReg = 2'b00;
  localparam logic [1:0] FuAlu = 2'b01;
  localparam logic [1:0] FuWb  = 2'b10;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

endpackage

// File: rtl/exe_stage_mc_if.sv
// Bundle of everything crossing the execute stage boundary except clock and reset.
// The master side is the ID/EXE register plus hazard logic; the slave side is the stage.
interface exe_stage_mc_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
);
  logic              freeze;
  logic              flush;
  logic [3:0]        exe_cmd;
  logic              s_in;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] val2_imm;
  logic              use_imm;
  logic [3:0]        sr_in;
  logic [REG_AW-1:0] dest_in;
  logic [1:0]        fu_sel_src1;
  logic [1:0]        fu_sel_src2;
  logic [DATA_W-1:0] alu_fwd;
  logic [DATA_W-1:0] wb_fwd;

  logic              stall;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] st_val;
  logic [DATA_W-1:0] pc;
  logic [REG_AW-1:0] dest;
  logic [3:0]        status;
  logic              status_we;

  modport master (
    output freeze, flush, exe_cmd, s_in, wb_en_in, mem_r_en_in, mem_w_en_in, pc_in,
           val_rn, val_rm, val2_imm, use_imm, sr_in, dest_in, fu_sel_src1, fu_sel_src2,
           alu_fwd, wb_fwd,
    input  stall, wb_en, mem_r_en, mem_w_en, alu_result, st_val, pc, dest, status, status_we
  );

  modport slave (
    input  freeze, flush, exe_cmd, s_in, wb_en_in, mem_r_en_in, mem_w_en_in, pc_in,
           val_rn, val_rm, val2_imm, use_imm, sr_in, dest_in, fu_sel_src1, fu_sel_src2,
           alu_fwd, wb_fwd,
    output stall, wb_en, mem_r_en, mem_w_en, alu_result, st_val, pc, dest, status, status_we
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative multiplier retiring MUL_BPC multiplier bits per cycle; product is the low DATA_W
// bits and stays on product_o until the next start.
module mul_iter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_BPC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              abort_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int unsigned NumIter = DATA_W / MUL_BPC;
  localparam int unsigned CntW    = (NumIter > 1) ? $clog2(NumIter) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumIter - 1);

  logic              busy_q;
  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, pp;

  // Shifting the multiplicand each step stands in for the << (k*MUL_BPC) of the partial product.
  assign pp = mcand_q * {{(DATA_W-MUL_BPC){1'b0}}, mplier_q[MUL_BPC-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (!hold_i) begin
      if (start_i && !busy_q) begin
        mcand_q  <= mcand_i;
        mplier_q <= mplier_i;
        acc_q    <= '0;
        cnt_q    <= '0;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        acc_q    <= acc_q + pp;
        mcand_q  <= mcand_q << MUL_BPC;
        mplier_q <= mplier_q >> MUL_BPC;
        if (cnt_q == LastCnt) begin
          cnt_q  <= '0;
          busy_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == LastCnt);
  assign product_o = acc_q;

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage with operand forwarding, flag generation, an iterative MUL and the EXE/MEM
// pipeline register. stall is combinational so the hazard unit can hold ID/EXE the same cycle.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned MUL_BPC = 4
) (
  input logic            clk,
  input logic            rst,
  exe_stage_mc_if.slave  bus
);

  typedef struct packed {
    logic              wb_en, mem_r_en, mem_w_en, status_we;
    logic [REG_AW-1:0] dest;
    logic [3:0]        status;
    logic [DATA_W-1:0] pc, st_val, alu_result;
  } out_t;

  typedef struct packed {
    logic              wb_en, mem_r_en, mem_w_en, s;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] pc, st_val;
  } cap_t;

  mul_state_e        state_q, state_d;
  out_t              out_q, out_d;
  cap_t              cap_q, cap_d;
  logic [DATA_W-1:0] src1, src2_reg, op2, b_eff, alu_res, mul_prod;
  logic [DATA_W:0]   sum;
  logic [3:0]        alu_flags, mul_flags;
  logic              arith, known, cin, mul_start, mul_busy, mul_done;

  always_comb begin
    case (bus.fu_sel_src1)
      FuReg:   src1 = bus.val_rn;
      FuAlu:   src1 = bus.alu_fwd;
      FuWb:    src1 = bus.wb_fwd;
      default: src1 = bus.val_rn;
    endcase
    case (bus.fu_sel_src2)
      FuReg:   src2_reg = bus.val_rm;
      FuAlu:   src2_reg = bus.alu_fwd;
      FuWb:    src2_reg = bus.wb_fwd;
      default: src2_reg = bus.val_rm;
    endcase
    op2 = bus.use_imm ? bus.val2_imm : src2_reg;
  end

  // Subtraction is a + ~b + cin, so the carry-out is already the ARM "NOT borrow".
  always_comb begin
    alu_res   = '0;
    alu_flags = bus.sr_in;
    arith     = 1'b0;
    known     = 1'b1;
    cin       = 1'b0;
    b_eff     = op2;
    case (bus.exe_cmd)
      CmdMov:  alu_res = op2;
      CmdMvn:  alu_res = ~op2;
      CmdAnd:  alu_res = src1 & op2;
      CmdOrr:  alu_res = src1 | op2;
      CmdEor:  alu_res = src1 ^ op2;
      CmdAdd:  arith = 1'b1;
      CmdAdc:  begin arith = 1'b1; cin = bus.sr_in[FlagC]; end
      CmdSub:  begin arith = 1'b1; cin = 1'b1; b_eff = ~op2; end
      CmdSbc:  begin arith = 1'b1; cin = bus.sr_in[FlagC]; b_eff = ~op2; end
      default: known = 1'b0;
    endcase
    sum = {1'b0, src1} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    if (arith) begin
      alu_res          = sum[DATA_W-1:0];
      alu_flags[FlagC] = sum[DATA_W];
      alu_flags[FlagV] = (src1[DATA_W-1] == b_eff[DATA_W-1]) &&
                         (sum[DATA_W-1] != src1[DATA_W-1]);
    end
    if (known) begin
      alu_flags[FlagN] = alu_res[DATA_W-1];
      alu_flags[FlagZ] = (alu_res == '0);
    end
  end

  always_comb begin
    mul_flags        = bus.sr_in;
    mul_flags[FlagN] = mul_prod[DATA_W-1];
    mul_flags[FlagZ] = (mul_prod == '0);
  end

  assign mul_start = (state_q == StIdle) && (bus.exe_cmd == CmdMul) &&
                     (bus.wb_en_in || bus.mem_r_en_in || bus.mem_w_en_in);
  assign bus.stall = mul_start || mul_busy;

  mul_iter #(
    .DATA_W  (DATA_W),
    .MUL_BPC (MUL_BPC)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (bus.freeze),
    .abort_i   (bus.flush),
    .start_i   (mul_start),
    .mcand_i   (src1),
    .mplier_i  (op2),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cap_d   = cap_q;
    if (bus.flush) begin
      state_d = StIdle;
      out_d   = '0;
    end else if (!bus.freeze) begin
      case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_d        = StBusy;
            out_d          = '0;
            cap_d.wb_en    = bus.wb_en_in;
            cap_d.mem_r_en = bus.mem_r_en_in;
            cap_d.mem_w_en = bus.mem_w_en_in;
            cap_d.s        = bus.s_in;
            cap_d.dest     = bus.dest_in;
            cap_d.pc       = bus.pc_in;
            cap_d.st_val   = src2_reg;
          end else begin
            out_d.wb_en      = bus.wb_en_in;
            out_d.mem_r_en   = bus.mem_r_en_in;
            out_d.mem_w_en   = bus.mem_w_en_in;
            out_d.status_we  = bus.s_in;
            out_d.dest       = bus.dest_in;
            out_d.status     = bus.s_in ? alu_flags : bus.sr_in;
            out_d.pc         = bus.pc_in;
            out_d.st_val     = src2_reg;
            out_d.alu_result = alu_res;
          end
        end
        StBusy: begin
          out_d = '0;
          if (mul_done) state_d = StDone;
        end
        StDone: begin
          state_d          = StIdle;
          out_d.wb_en      = cap_q.wb_en;
          out_d.mem_r_en   = cap_q.mem_r_en;
          out_d.mem_w_en   = cap_q.mem_w_en;
          out_d.status_we  = cap_q.s;
          out_d.dest       = cap_q.dest;
          out_d.status     = cap_q.s ? mul_flags : bus.sr_in;
          out_d.pc         = cap_q.pc;
          out_d.st_val     = cap_q.st_val;
          out_d.alu_result = mul_prod;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cap_q   <= cap_d;
    end
  end

  assign bus.wb_en      = out_q.wb_en;
  assign bus.mem_r_en   = out_q.mem_r_en;
  assign bus.mem_w_en   = out_q.mem_w_en;
  assign bus.status_we  = out_q.status_we;
  assign bus.dest       = out_q.dest;
  assign bus.status     = out_q.status;
  assign bus.pc         = out_q.pc;
  assign bus.st_val     = out_q.st_val;
  assign bus.alu_result = out_q.alu_result;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Self-checking bench for exe_stage_mc: an independent reference model fills a scoreboard
// when each operation is presented; entries are popped when the stage retires a result.
module tb_exe_stage_mc;

  localparam logic [3:0] OpMov = 4'b0001, OpMvn = 4'b1001, OpAdd = 4'b0010, OpAdc = 4'b0011;
  localparam logic [3:0] OpSub = 4'b0100, OpSbc = 4'b0101, OpAnd = 4'b0110, OpOrr = 4'b0111;
  localparam logic [3:0] OpEor = 4'b1000, OpMul = 4'b1010;
  localparam longint Two32 = 64'sh1_0000_0000;
  localparam longint SMax  = 64'sh7FFF_FFFF;
  localparam longint SMin  = -64'sh8000_0000;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] rn, rm, imm;
    logic        uimm;
    logic [1:0]  sel1, sel2;
    logic [31:0] afwd, wfwd;
    logic        s, wb, mr, mw;
    logic [3:0]  sr, dst;
    logic [31:0] pc;
  } stim_t;

  typedef struct packed {
    logic        wb, mr, mw, swe;
    logic [3:0]  dest, status;
    logic [31:0] pc, st_val, res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  exe_stage_mc_if #(.DATA_W(32), .REG_AW(4)) bus ();

  exe_stage_mc #(.DATA_W(32), .REG_AW(4), .MUL_BPC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r, a, w);
    return (sel == 2'b01) ? a : (sel == 2'b10) ? w : r;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t        e;
    logic [31:0] a, b2, op2, r;
    logic [63:0] p;
    logic        n, z, c, v, known;
    longint      ua, ub, sa, sbv, nb;
    a   = pick(s.sel1, s.rn, s.afwd, s.wfwd);
    b2  = pick(s.sel2, s.rm, s.afwd, s.wfwd);
    op2 = s.uimm ? s.imm : b2;
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, op2});
    sa  = longint'($signed(a));
    sbv = longint'($signed(op2));
    nb  = s.sr[1] ? 0 : 1;
    c = s.sr[1]; v = s.sr[0]; r = '0; known = 1'b1;
    case (s.cmd)
      OpMov: r = op2;
      OpMvn: r = ~op2;
      OpAnd: r = a & op2;
      OpOrr: r = a | op2;
      OpEor: r = a ^ op2;
      OpAdd: begin r = 32'(ua + ub); c = (ua + ub) >= Two32; v = (sa + sbv > SMax) || (sa + sbv < SMin); end
      OpAdc: begin r = 32'(ua + ub + 1 - nb); c = (ua + ub + 1 - nb) >= Two32;
                   v = (sa + sbv + 1 - nb > SMax) || (sa + sbv + 1 - nb < SMin); end
      OpSub: begin r = 32'(ua - ub); c = ua >= ub; v = (sa - sbv > SMax) || (sa - sbv < SMin); end
      OpSbc: begin r = 32'(ua - ub - nb); c = ua >= ub + nb;
                   v = (sa - sbv - nb > SMax) || (sa - sbv - nb < SMin); end
      OpMul: begin
        known = s.wb | s.mr | s.mw;
        p = {32'b0, a} * {32'b0, op2};
        if (known) r = p[31:0];
      end
      default: known = 1'b0;
    endcase
    n = r[31]; z = (r == 32'd0);
    e.wb = s.wb; e.mr = s.mr; e.mw = s.mw; e.swe = s.s; e.dest = s.dst;
    e.pc = s.pc; e.st_val = b2; e.res = r;
    e.status = (s.s && known) ? {n, z, c, v} : s.sr;
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.wb = bus.wb_en; o.mr = bus.mem_r_en; o.mw = bus.mem_w_en; o.swe = bus.status_we;
    o.dest = bus.dest; o.status = bus.status; o.pc = bus.pc; o.st_val = bus.st_val;
    o.res = bus.alu_result;
    return o;
  endfunction

  function automatic stim_t mk(input logic [3:0] cmd, input logic [31:0] rn, rm);
    stim_t s = '0;
    s.cmd = cmd; s.rn = rn; s.rm = rm; s.s = 1'b1; s.wb = 1'b1; s.dst = 4'd3; s.pc = 32'h100;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop_inputs();
    bus.exe_cmd = '0; bus.s_in = 0; bus.wb_en_in = 0; bus.mem_r_en_in = 0; bus.mem_w_en_in = 0;
    bus.pc_in = '0; bus.val_rn = '0; bus.val_rm = '0; bus.val2_imm = '0; bus.use_imm = 0;
    bus.sr_in = '0; bus.dest_in = '0; bus.fu_sel_src1 = '0; bus.fu_sel_src2 = '0;
    bus.alu_fwd = '0; bus.wb_fwd = '0;
  endtask

  task automatic send(input stim_t s);
    bus.exe_cmd = s.cmd; bus.val_rn = s.rn; bus.val_rm = s.rm; bus.val2_imm = s.imm;
    bus.use_imm = s.uimm; bus.fu_sel_src1 = s.sel1; bus.fu_sel_src2 = s.sel2;
    bus.alu_fwd = s.afwd; bus.wb_fwd = s.wfwd; bus.s_in = s.s; bus.wb_en_in = s.wb;
    bus.mem_r_en_in = s.mr; bus.mem_w_en_in = s.mw; bus.sr_in = s.sr; bus.dest_in = s.dst;
    bus.pc_in = s.pc;
    sb.push_back(model(s));
    #1;
  endtask

  task automatic test_reset();
    exp_t o, e;
    rst = 1'b1; bus.freeze = 1'b1; bus.flush = 1'b0; nop_inputs();
    tick(); tick();
    o = observed();
    n_checks++;
    if (o !== exp_t'('0)) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", o); end
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    rst = 1'b0; bus.freeze = 1'b0;
    send(mk(OpAdd, 32'd20, 32'd22));
    tick();
    e = sb.pop_front();
    o = observed();
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL reset_pre_op: got %h want %h", o, e); end
    rst = 1'b1; bus.freeze = 1'b1; bus.flush = 1'b1;
    tick();
    o = observed();
    n_checks++;
    if (o !== exp_t'('0)) begin n_fail++; $display("FAIL reset_overrides: got %h want 0", o); end
    rst = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0; nop_inputs();
    tick();
  endtask

  task automatic test_alu();
    stim_t       t[$];
    logic [31:0] xr[$];
    logic [3:0]  xs[$];
    stim_t       s;
    exp_t        o, e;
    s = mk(OpAdd, 5, 7);                                   t.push_back(s); xr.push_back(12);           xs.push_back(4'b0000);
    s = mk(OpSub, 3, 5);                                   t.push_back(s); xr.push_back(32'hFFFFFFFE); xs.push_back(4'b1000);
    s = mk(OpAdd, 32'h7FFFFFFF, 1);                        t.push_back(s); xr.push_back(32'h80000000); xs.push_back(4'b1001);
    s = mk(OpEor, 9999, 8888); s.sel1 = 2'b01; s.afwd = 100; s.sel2 = 2'b10; s.wfwd = 23;
                                                           t.push_back(s); xr.push_back(115);          xs.push_back(4'b0000);
    s = mk(OpEor, 32'hF0, 32'h0F); s.sel1 = 2'b11; s.sel2 = 2'b11; s.afwd = 1; s.wfwd = 2;
                                                           t.push_back(s); xr.push_back(32'hFF);       xs.push_back(4'b0000);
    s = mk(OpOrr, 32'h10, 32'hAA); s.uimm = 1; s.imm = 1; s.sr = 4'b0011;
                                                           t.push_back(s); xr.push_back(32'h11);       xs.push_back(4'b0011);
    s = mk(OpAdc, 32'hFFFFFFFF, 0); s.sr = 4'b0010;        t.push_back(s); xr.push_back(0);            xs.push_back(4'b0110);
    s = mk(OpSbc, 5, 3);                                   t.push_back(s); xr.push_back(1);            xs.push_back(4'b0010);
    s = mk(OpMvn, 7, 0); s.sr = 4'b0001;                   t.push_back(s); xr.push_back(32'hFFFFFFFF); xs.push_back(4'b1001);
    s = mk(4'hF, 7, 9); s.sr = 4'b0101;                    t.push_back(s); xr.push_back(0);            xs.push_back(4'b0101);
    s = mk(OpAdd, 1, 1); s.s = 0; s.sr = 4'b1010;          t.push_back(s); xr.push_back(2);            xs.push_back(4'b1010);
    s = mk(OpSub, 5, 5); s.mw = 1; s.wb = 0; s.dst = 4'hA; t.push_back(s); xr.push_back(0);            xs.push_back(4'b0110);
    s = mk(OpAnd, 32'hF0F0, 32'hFF00); s.mr = 1;           t.push_back(s); xr.push_back(32'hF000);     xs.push_back(4'b0000);
    s = mk(OpMov, 0, 32'h8000_0001); s.sr = 4'b0110;       t.push_back(s); xr.push_back(32'h80000001); xs.push_back(4'b1010);
    foreach (t[i]) begin
      send(t[i]);
      n_checks++;
      if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall[%0d]: got %b want 0", i, bus.stall); end
      tick();
      e = sb.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL alu_model[%0d]: got %h want %h", i, o, e); end
      n_checks++;
      if (o.res !== xr[i] || o.status !== xs[i]) begin
        n_fail++;
        $display("FAIL alu_const[%0d]: got %h/%b want %h/%b", i, o.res, o.status, xr[i], xs[i]);
      end
    end
    nop_inputs();
    tick();
  endtask

  task automatic test_mul();
    stim_t       t[2];
    logic [31:0] xr[2];
    logic [3:0]  xs[2];
    exp_t        o, e;
    int          n;
    t[0] = mk(OpMul, 6, 7);                              xr[0] = 42;           xs[0] = 4'b0000;
    t[1] = mk(OpMul, 32'hFFFFFFFF, 2); t[1].sr = 4'b0011; xr[1] = 32'hFFFFFFFE; xs[1] = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      send(t[i]);
      n = 0;
      while (bus.stall && n < 40) begin
        tick();
        n++;
        o = observed();
        n_checks++;
        if (bus.stall && o !== exp_t'('0)) begin n_fail++; $display("FAIL mul_bubble[%0d]: got %h want 0", i, o); end
      end
      n_checks++;
      if (n != 9) begin n_fail++; $display("FAIL mul_stall_cycles[%0d]: got %0d want 9", i, n); end
      tick();
      e = sb.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mul_model[%0d]: got %h want %h", i, o, e); end
      n_checks++;
      if (o.res !== xr[i] || o.status !== xs[i] || o.wb !== 1'b1) begin
        n_fail++;
        $display("FAIL mul_const[%0d]: got %h/%b/%b want %h/%b/1", i, o.res, o.status, o.wb, xr[i], xs[i]);
      end
      nop_inputs();
    end
    tick();
  endtask

  task automatic test_flush();
    exp_t o, e;
    send(mk(OpMul, 6, 7));
    repeat (4) tick();
    n_checks++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall: got %b want 1", bus.stall); end
    bus.flush = 1'b1;
    nop_inputs();
    tick();
    bus.flush = 1'b0;
    e = sb.pop_back();
    o = observed();
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", bus.stall); end
    n_checks++;
    if (o !== exp_t'('0)) begin n_fail++; $display("FAIL flush_bubble: got %h want 0", o); end
    repeat (12) begin
      tick();
      n_checks++;
      if (bus.wb_en !== 1'b0 || bus.alu_result !== 32'd0) begin
        n_fail++;
        $display("FAIL flush_no_retire: got wb=%b res=%h want 0/0", bus.wb_en, bus.alu_result);
      end
    end
    send(mk(OpAdd, 1, 2));
    n_checks++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 0", bus.stall); end
    tick();
    e = sb.pop_front();
    o = observed();
    n_checks++;
    if (o !== e || o.res !== 32'd3) begin n_fail++; $display("FAIL flush_recover: got %h want %h", o, e); end
    nop_inputs();
    tick();
  endtask

  task automatic test_rst_mid_mul();
    exp_t o, e;
    int   n;
    send(mk(OpMul, 9, 9));
    repeat (5) tick();
    rst = 1'b1;
    nop_inputs();
    tick();
    rst = 1'b0;
    e = sb.pop_back();
    o = observed();
    n_checks++;
    if (o !== exp_t'('0) || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_mul: got %h stall=%b want 0 stall=0", o, bus.stall);
    end
    send(mk(OpMul, 9, 9));
    n = 0;
    while (bus.stall && n < 40) begin tick(); n++; end
    n_checks++;
    if (n != 9) begin n_fail++; $display("FAIL rst_mul_cycles: got %0d want 9", n); end
    tick();
    e = sb.pop_front();
    o = observed();
    n_checks++;
    if (o !== e || o.res !== 32'd81) begin n_fail++; $display("FAIL rst_mul_result: got %h want %h", o, e); end
    nop_inputs();
    tick();
  endtask

  task automatic test_freeze();
    exp_t o, e;
    int   n;
    send(mk(OpMul, 123456, 789));
    repeat (3) tick();
    bus.freeze = 1'b1;
    repeat (3) begin
      tick();
      o = observed();
      n_checks++;
      if (bus.stall !== 1'b1 || o !== exp_t'('0)) begin
        n_fail++;
        $display("FAIL freeze_hold: got stall=%b out=%h want 1/0", bus.stall, o);
      end
    end
    bus.freeze = 1'b0;
    n = 3;
    while (bus.stall && n < 40) begin tick(); n++; end
    n_checks++;
    if (n != 9) begin n_fail++; $display("FAIL freeze_cycles: got %0d want 9", n); end
    tick();
    e = sb.pop_front();
    o = observed();
    n_checks++;
    if (o !== e || o.res !== 32'd97406784) begin n_fail++; $display("FAIL freeze_result: got %h want %h", o, e); end
    nop_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[12];
    stim_t      s;
    exp_t       o, e;
    int         n, want;
    ops = '{OpMov, OpMvn, OpAdd, OpAdc, OpSub, OpSbc, OpAnd, OpOrr, OpEor, OpMul, 4'h0, 4'hF};
    for (int i = 0; i < 30; i++) begin
      s = mk(ops[$urandom_range(0, 11)], $urandom, $urandom);
      s.imm = $urandom; s.uimm = $urandom_range(0, 1);
      s.sel1 = 2'($urandom_range(0, 3)); s.sel2 = 2'($urandom_range(0, 3));
      s.afwd = $urandom; s.wfwd = $urandom;
      s.s = $urandom_range(0, 1); s.mr = $urandom_range(0, 1); s.mw = $urandom_range(0, 1);
      s.sr = 4'($urandom_range(0, 15)); s.dst = 4'($urandom_range(0, 15)); s.pc = $urandom;
      if (i % 5 == 0) s.rm = 32'd0;
      send(s);
      want = (s.cmd == OpMul) ? 9 : 0;
      n = 0;
      while (bus.stall && n < 40) begin tick(); n++; end
      n_checks++;
      if (n != want) begin n_fail++; $display("FAIL b2b_stall[%0d]: got %0d want %0d", i, n, want); end
      tick();
      e = sb.pop_front();
      o = observed();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b[%0d] cmd=%h: got %h want %h", i, s.cmd, o, e); end
    end
    nop_inputs();
    tick();
  endtask

  initial begin
    bus.freeze = 1'b0;
    bus.flush  = 1'b0;
    nop_inputs();
    test_reset();
    test_alu();
    test_mul();
    test_flush();
    test_rst_mid_mul();
    test_freeze();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
